// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port codes, flit type codes, one-hot request bit positions.
package router_pkg;

  localparam logic [3:0] PORT_NONE = 4'd0;
  localparam logic [3:0] PORT_L    = 4'd1;
  localparam logic [3:0] PORT_E    = 4'd2;
  localparam logic [3:0] PORT_N    = 4'd3;
  localparam logic [3:0] PORT_W    = 4'd4;
  localparam logic [3:0] PORT_S    = 4'd5;

  localparam logic [1:0] FT_BODY    = 2'b00;
  localparam logic [1:0] FT_TAIL    = 2'b01;
  localparam logic [1:0] FT_HDR     = 2'b10;
  localparam logic [1:0] FT_HDRTAIL = 2'b11;

  localparam int OH_L = 0;
  localparam int OH_E = 1;
  localparam int OH_W = 2;
  localparam int OH_S = 3;
  localparam int OH_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } rc_state_e;

  function automatic logic [4:0] port_onehot(input logic [3:0] port);
    logic [4:0] oh;
    oh = '0;
    case (port)
      PORT_L:  oh[OH_L] = 1'b1;
      PORT_E:  oh[OH_E] = 1'b1;
      PORT_W:  oh[OH_W] = 1'b1;
      PORT_S:  oh[OH_S] = 1'b1;
      PORT_N:  oh[OH_N] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/route_calc_dor.sv
// Combinational dimension-ordered route: port code from destination vs. this node, plus mesh range check.
// Latency 0; no flow control.
module route_calc_dor
  import router_pkg::*;
#(
  parameter int X_NODE_NUM = 4,
  parameter int Y_NODE_NUM = 4,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int X_ADDR     = 2,
  parameter int Y_ADDR     = 3,
  parameter int ROUTING    = 0
) (
  input  logic [X_W-1:0] dest_x,
  input  logic [Y_W-1:0] dest_y,
  output logic [3:0]     port,
  output logic           in_range
);

  localparam logic signed [X_W:0] XA = (X_W+1)'(X_ADDR);
  localparam logic signed [Y_W:0] YA = (Y_W+1)'(Y_ADDR);

  logic signed [X_W:0] xdiff;
  logic signed [Y_W:0] ydiff;
  logic [3:0]          xport;
  logic [3:0]          yport;

  assign xdiff = $signed({1'b0, dest_x}) - XA;
  assign ydiff = $signed({1'b0, dest_y}) - YA;

  // Sign bit picks direction; caller only uses these when the diff is non-zero.
  assign xport = xdiff[X_W] ? PORT_W : PORT_E;
  assign yport = ydiff[Y_W] ? PORT_N : PORT_S;

  always_comb begin
    port = PORT_L;
    if (ROUTING == 0) begin
      if (xdiff != '0)      port = xport;
      else if (ydiff != '0) port = yport;
    end else begin
      if (ydiff != '0)      port = yport;
      else if (xdiff != '0) port = xport;
    end
  end

  assign in_range = (int'(dest_x) < X_NODE_NUM) && (int'(dest_y) < Y_NODE_NUM);

endmodule

// File: rtl/route_compute_seq.sv
// Per-input-port route compute: registers the DOR route of a header and holds a one-hot request until the tail.
// Latency 1 header->out_req; flits consumed only on sw_grant while ACTIVE, freely while dropping or discarding.
module route_compute_seq
  import router_pkg::*;
#(
  parameter int X_NODE_NUM = 4,
  parameter int Y_NODE_NUM = 4,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int X_ADDR     = 2,
  parameter int Y_ADDR     = 3,
  parameter int FLIT_W     = 8,
  parameter int ROUTING    = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sw_grant,
  output logic [3:0]        port_num,
  output logic [4:0]        out_req,
  output logic              seq_err,
  output logic              dest_err,
  output logic [CNT_W-1:0]  pkt_cnt
);

  rc_state_e        state_q, state_d;
  logic [3:0]       port_q, port_d;
  logic [4:0]       req_q, req_d;
  logic             taken_q, taken_d;
  logic             seq_err_q, seq_err_d;
  logic             dest_err_q, dest_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_c;

  logic [1:0] ftype;
  logic       is_head;
  logic       is_tail;
  logic [3:0] calc_port;
  logic       calc_in_range;

  assign ftype   = flit_in[FLIT_W-1:FLIT_W-2];
  assign is_head = ftype[1];
  assign is_tail = ftype[0];

  generate
    if (FLIT_W > X_W + Y_W + 2) begin : g_spare
      logic unused_flit_bits;
      assign unused_flit_bits = ^flit_in[FLIT_W-3:X_W+Y_W];
    end
  endgenerate

  route_calc_dor #(
    .X_NODE_NUM (X_NODE_NUM),
    .Y_NODE_NUM (Y_NODE_NUM),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .X_ADDR     (X_ADDR),
    .Y_ADDR     (Y_ADDR),
    .ROUTING    (ROUTING)
  ) u_dor (
    .dest_x   (flit_in[X_W-1:0]),
    .dest_y   (flit_in[X_W+Y_W-1:X_W]),
    .port     (calc_port),
    .in_range (calc_in_range)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    req_d      = req_q;
    taken_d    = taken_q;
    seq_err_d  = seq_err_q;
    dest_err_d = dest_err_q;
    cnt_d      = cnt_q;
    rdy_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_head) begin
            if (calc_in_range) begin
              port_d  = calc_port;
              req_d   = port_onehot(calc_port);
              taken_d = 1'b0;
              state_d = ST_ACTIVE;
            end else begin
              dest_err_d = 1'b1;
              state_d    = ST_DROP;
            end
          end else begin
            seq_err_d = 1'b1;
            rdy_c     = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        rdy_c = in_valid && sw_grant;
        if (rdy_c) begin
          taken_d = 1'b1;
          // The header that opened the packet is the first flit consumed; any later head is a sequence error.
          if (is_head && taken_q) seq_err_d = 1'b1;
          if (is_tail || (is_head && taken_q)) begin
            cnt_d   = cnt_q + 1'b1;
            port_d  = PORT_NONE;
            req_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        rdy_c = in_valid;
        if (in_valid && is_tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_NONE;
      req_q      <= '0;
      taken_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      dest_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      req_q      <= req_d;
      taken_q    <= taken_d;
      seq_err_q  <= seq_err_d;
      dest_err_q <= dest_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Gated so nothing is consumed while reset is held.
  assign in_ready = rdy_c & reset_n;
  assign port_num = port_q;
  assign out_req  = req_q;
  assign seq_err  = seq_err_q;
  assign dest_err = dest_err_q;
  assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_route_compute_seq.sv
// Directed bench: four route_compute_seq variants share one stimulus stream; each scenario checks the relevant one.
module tb_route_compute_seq;
  import router_pkg::*;

  localparam int XY = 0;
  localparam int YX = 1;
  localparam int X3 = 2;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] flit_in = '0;
  logic       in_valid = 1'b0;
  logic       sw_grant = 1'b0;

  logic        rdy  [4];
  logic [3:0]  pnum [4];
  logic [4:0]  req  [4];
  logic        serr [4];
  logic        derr [4];
  logic [15:0] cnt  [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  route_compute_seq u_xy (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .in_valid(in_valid), .in_ready(rdy[XY]),
    .sw_grant(sw_grant), .port_num(pnum[XY]), .out_req(req[XY]), .seq_err(serr[XY]),
    .dest_err(derr[XY]), .pkt_cnt(cnt[XY])
  );

  route_compute_seq #(.ROUTING(1)) u_yx (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .in_valid(in_valid), .in_ready(rdy[YX]),
    .sw_grant(sw_grant), .port_num(pnum[YX]), .out_req(req[YX]), .seq_err(serr[YX]),
    .dest_err(derr[YX]), .pkt_cnt(cnt[YX])
  );

  route_compute_seq #(.X_NODE_NUM(3)) u_x3 (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .in_valid(in_valid), .in_ready(rdy[X3]),
    .sw_grant(sw_grant), .port_num(pnum[X3]), .out_req(req[X3]), .seq_err(serr[X3]),
    .dest_err(derr[X3]), .pkt_cnt(cnt[X3])
  );

  route_compute_seq #(.Y_ADDR(1)) u_sd (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .in_valid(in_valid), .in_ready(rdy[SD]),
    .sw_grant(sw_grant), .port_num(pnum[SD]), .out_req(req[SD]), .seq_err(serr[SD]),
    .dest_err(derr[SD]), .pkt_cnt(cnt[SD])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] t, input logic [1:0] x, input logic [1:0] y,
                       input logic v, input logic g);
    flit_in  = {t, 2'b00, y, x};
    in_valid = v;
    sw_grant = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    sw_grant = 1'b0;
    reset_n  = 1'b0;
    #3;
    reset_n  = 1'b1;
    step();
  endtask

  initial begin
    // Reset state, with a body flit presented to show in_ready is held low.
    drive(FT_BODY, 2'd0, 2'd0, 1'b1, 1'b1);
    #12;
    chk("rst_port",   32'(pnum[XY]), 0);
    chk("rst_req",    32'(req[XY]),  0);
    chk("rst_rdy",    32'(rdy[XY]),  0);
    chk("rst_seqerr", 32'(serr[XY]), 0);
    chk("rst_desterr",32'(derr[XY]), 0);
    chk("rst_cnt",    32'(cnt[XY]),  0);
    in_valid = 1'b0;
    sw_grant = 1'b0;
    reset_n  = 1'b1;
    step();

    // XY, node (2,3): head to (0,3) routes W, then body and tail.
    drive(FT_HDR, 2'd0, 2'd3, 1'b1, 1'b0);
    @(negedge clk); chk("a_rdy_idle", 32'(rdy[XY]), 0);
    step();
    chk("a_port", 32'(pnum[XY]), 4);
    chk("a_req",  32'(req[XY]),  'b00100);
    @(negedge clk); chk("a_rdy_nogrant", 32'(rdy[XY]), 0);
    step();
    chk("a_req_hold", 32'(req[XY]), 'b00100);
    sw_grant = 1'b1;
    @(negedge clk); chk("a_rdy_head", 32'(rdy[XY]), 1);
    step();
    drive(FT_BODY, 2'd0, 2'd0, 1'b1, 1'b1);
    @(negedge clk); chk("a_rdy_body", 32'(rdy[XY]), 1);
    step();
    drive(FT_TAIL, 2'd0, 2'd0, 1'b1, 1'b1);
    @(negedge clk); chk("a_rdy_tail", 32'(rdy[XY]), 1);
    step();
    in_valid = 1'b0;
    sw_grant = 1'b0;
    chk("a_req_after", 32'(req[XY]),  0);
    chk("a_port_after",32'(pnum[XY]), 0);
    chk("a_cnt",       32'(cnt[XY]),  1);
    chk("a_seqerr",    32'(serr[XY]), 0);

    // XY vs YX for dest (3,0).
    do_reset();
    drive(FT_HDR, 2'd3, 2'd0, 1'b1, 1'b0);
    step();
    chk("b_xy_port", 32'(pnum[XY]), 2);
    chk("b_xy_req",  32'(req[XY]),  'b00010);
    chk("b_yx_port", 32'(pnum[YX]), 3);
    chk("b_yx_req",  32'(req[YX]),  'b10000);
    in_valid = 1'b0;

    // Local single-flit packet, granted in cycle 1.
    do_reset();
    drive(FT_HDRTAIL, 2'd2, 2'd3, 1'b1, 1'b0);
    step();
    chk("c_port", 32'(pnum[XY]), 1);
    chk("c_req",  32'(req[XY]),  'b00001);
    sw_grant = 1'b1;
    @(negedge clk); chk("c_rdy", 32'(rdy[XY]), 1);
    step();
    in_valid = 1'b0;
    sw_grant = 1'b0;
    chk("c_port_idle", 32'(pnum[XY]), 0);
    chk("c_req_idle",  32'(req[XY]),  0);
    chk("c_cnt",       32'(cnt[XY]),  1);

    // Out of range on the 3-column mesh: head (3,1) is dropped with its body and tail.
    do_reset();
    drive(FT_HDR, 2'd3, 2'd1, 1'b1, 1'b0);
    @(negedge clk); chk("d_rdy_idle", 32'(rdy[X3]), 0);
    step();
    chk("d_desterr", 32'(derr[X3]), 1);
    chk("d_req",     32'(req[X3]),  0);
    chk("d_port",    32'(pnum[X3]), 0);
    drive(FT_BODY, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk); chk("d_rdy_body", 32'(rdy[X3]), 1);
    step();
    drive(FT_TAIL, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk); chk("d_rdy_tail", 32'(rdy[X3]), 1);
    step();
    in_valid = 1'b0;
    chk("d_cnt",     32'(cnt[X3]),  0);
    chk("d_req_end", 32'(req[X3]),  0);
    drive(FT_HDR, 2'd0, 2'd3, 1'b1, 1'b0);
    step();
    chk("d_next_port",    32'(pnum[X3]), 4);
    chk("d_desterr_stky", 32'(derr[X3]), 1);
    in_valid = 1'b0;

    // Second head while ACTIVE closes and counts the packet.
    do_reset();
    drive(FT_HDR, 2'd0, 2'd3, 1'b1, 1'b0);
    step();
    sw_grant = 1'b1;
    step();
    chk("e_seqerr_pre", 32'(serr[XY]), 0);
    drive(FT_HDR, 2'd1, 2'd3, 1'b1, 1'b1);
    @(negedge clk); chk("e_rdy_head2", 32'(rdy[XY]), 1);
    step();
    in_valid = 1'b0;
    sw_grant = 1'b0;
    chk("e_seqerr", 32'(serr[XY]), 1);
    chk("e_cnt",    32'(cnt[XY]),  1);
    chk("e_req",    32'(req[XY]),  0);

    // Body in IDLE is discarded and flagged.
    do_reset();
    drive(FT_BODY, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk); chk("e_rdy_body", 32'(rdy[XY]), 1);
    step();
    in_valid = 1'b0;
    chk("e_seqerr_body", 32'(serr[XY]), 1);
    chk("e_port_body",   32'(pnum[XY]), 0);
    chk("e_cnt_body",    32'(cnt[XY]),  0);

    // Asynchronous reset mid-packet on node (2,1): head (2,3) routes S.
    do_reset();
    drive(FT_HDR, 2'd2, 2'd3, 1'b1, 1'b0);
    step();
    chk("f_port", 32'(pnum[SD]), 5);
    chk("f_req",  32'(req[SD]),  'b01000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("f_req_rst",  32'(req[SD]),  0);
    chk("f_port_rst", 32'(pnum[SD]), 0);
    #1;
    reset_n = 1'b1;
    step();
    chk("f_port_again", 32'(pnum[SD]), 5);
    chk("f_req_again",  32'(req[SD]),  'b01000);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/route_compute_seq.md
Name: route_compute_seq

Overview:
- Registered, packet-aware route-compute unit; one instance per router input port in the 5-port mesh router.
- Samples a header flit and computes the output port by dimension-ordered routing (XY or YX, chosen by parameter) for a parametrised mesh.
- Holds that route as a one-hot switch request until the tail flit is forwarded.
- Detects illegal flit sequences and out-of-range destinations, drops the offending packets, and counts routed packets.

Parameters:
- X_NODE_NUM, 4, mesh columns.
- Y_NODE_NUM, 4, mesh rows.
- X_W, 2, dest-x field width (ceil log2 X_NODE_NUM, min 1).
- Y_W, 2, dest-y field width.
- X_ADDR, 2, this node's x coordinate.
- Y_ADDR, 3, this node's y coordinate.
- FLIT_W, 8, flit width; must be >= X_W+Y_W+2.
- ROUTING, 0, 0 = XY (x first), 1 = YX (y first).
- CNT_W, 16, packet counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flit_in  in  FLIT_W  flit field layout:
  - [X_W-1:0] dest x
  - [X_W+Y_W-1:X_W] dest y
  - [FLIT_W-1:FLIT_W-2] type: 10 head, 00 body, 01 tail, 11 head+tail
- in_valid  in  1  flit_in valid.
- in_ready  out  1  flit consumed this cycle (in_valid && in_ready).
- sw_grant  in  1  switch allocator grants the held request this cycle.
- port_num  out  4  registered port code: 0 none, 1 L, 2 E, 3 N, 4 W, 5 S.
- out_req  out  5  one-hot request, bit order [0]=L, [1]=E, [2]=W, [3]=S, [4]=N.
- seq_err  out  1  sticky: body/tail seen in IDLE.
- dest_err  out  1  sticky: destination outside mesh.
- pkt_cnt  out  CNT_W  packets fully forwarded (tail consumed), wraps.

Behaviour:
- Reset (async, reset_n=0) forces the following; takes effect immediately, mid-packet included, discarding any held route:
  - state IDLE
  - port_num=0, out_req=0, in_ready=0
  - seq_err=0, dest_err=0, pkt_cnt=0
- Arithmetic:
  - xdiff = dest_x - X_ADDR and ydiff = dest_y - Y_ADDR, signed, one bit wider than the field.
  - Positive xdiff routes E, negative routes W.
  - Positive ydiff routes S, negative routes N.
  - Both zero routes L.
  - XY resolves x fully before y; YX resolves y fully before x.
- States:
  - IDLE:
    - in_ready=0; the flit is observed, not consumed.
    - in_valid with type head or head+tail and dest in range: register port_num and out_req from the combinational route; go to ACTIVE. out_req is visible the cycle after the header is presented (latency 1).
    - Head with dest_x >= X_NODE_NUM or dest_y >= Y_NODE_NUM: set dest_err; go to DROP.
    - in_valid with body/tail: set seq_err; in_ready=1 for that cycle (flit discarded); stay IDLE.
  - ACTIVE:
    - out_req held constant; in_ready = in_valid && sw_grant.
    - Consumed tail or head+tail: pkt_cnt+1, then IDLE next cycle with port_num=0 and out_req=0.
    - Consumed head while ACTIVE, i.e. any head after the first flit of the packet: set seq_err, treat it as a tail (close packet, count it).
    - No grant: hold; no timeout.
  - DROP:
    - in_ready=in_valid; out_req=0; port_num=0.
    - Consumed tail/head+tail returns to IDLE without incrementing pkt_cnt. Head+tail with bad dest returns to IDLE after one consume cycle.
- sw_grant in IDLE/DROP is ignored.
- Back-to-back packets: IDLE is always visited for ≥1 cycle between packets, so the minimum gap is 1 cycle.
- pkt_cnt wraps from all-ones to 0 silently.
- Error flags clear only on reset.

Decomposition:
- Shared package router_pkg holds:
  - port code constants PORT_L/E/N/W/S
  - flit type constants HDR/BODY/TAIL/HDRTAIL
  - one-hot bit index constants
- One combinational sub-module, route_calc_dor (params as above plus ROUTING; in dest_x, dest_y; out port code and in_range).
- The FSM, registers and counter live in route_compute_seq.

Test Plan:
- Defaults, node (2,3), XY:
  - head dest (0,3) -> next cycle port_num=4, out_req=00100.
  - grant with body then tail -> in_ready high both cycles, pkt_cnt=1, out_req=0 the cycle after the tail.
- XY vs YX: head dest (3,0):
  - ROUTING=0 -> port_num=2, out_req=00010
  - ROUTING=1 -> port_num=3, out_req=10000
- Local and single-flit: head+tail dest (2,3) with sw_grant=1 in cycle 1 -> port_num=1, out_req=00001, consumed in cycle 1, IDLE cycle 2, pkt_cnt=1.
- Out of range: X_NODE_NUM=3, head dest (3,1) -> dest_err=1, out_req stays 0, body+tail consumed at one per cycle, pkt_cnt unchanged.
- Sequence errors:
  - body in IDLE -> seq_err=1, flit consumed.
  - second head during ACTIVE with grant -> seq_err=1, packet closed, pkt_cnt+1.
- Reset mid-packet: assert reset_n=0 asynchronously in ACTIVE with out_req=01000 -> out_req=0 and port_num=0 immediately. After release, a fresh head routes normally.
